// File: rtl/aluop_decode_pipe_if.sv
// ---------------------------------------------------------------------------
// aluop_decode_pipe_if
// Bundles the upstream (class flags + tag) and downstream (aluop + tag)
// valid/ready channels of the ALU-op decode pipe, plus flush and the
// illegal-decode counter.
//   master : the instruction-decode / execute side that drives the pipe
//   slave  : the decode pipe itself
// Signals:
//   valid_i/ready_o        upstream handshake
//   rtype_i..csr_i, tag_i  one-hot class flags and opaque tag
//   flush_i                synchronous pipeline flush
//   valid_o/ready_i        downstream handshake
//   aluop_o, illegal_o     decoded op code and not-one-hot flag
//   tag_o                  tag travelling with the output entry
//   illegal_cnt_o          saturating count of accepted illegal entries
// ---------------------------------------------------------------------------
interface aluop_decode_pipe_if #(
  parameter int ALUOP_W = 4,
  parameter int TAG_W   = 5,
  parameter int CNT_W   = 8
) ();
  logic               valid_i;
  logic               ready_o;
  logic               rtype_i;
  logic               itype_i;
  logic               store_i;
  logic               load_i;
  logic               branch_i;
  logic               jal_i;
  logic               jalr_i;
  logic               lui_i;
  logic               auipc_i;
  logic               csr_i;
  logic [TAG_W-1:0]   tag_i;
  logic               flush_i;
  logic               valid_o;
  logic               ready_i;
  logic [ALUOP_W-1:0] aluop_o;
  logic               illegal_o;
  logic [TAG_W-1:0]   tag_o;
  logic [CNT_W-1:0]   illegal_cnt_o;

  modport master (
    output valid_i, rtype_i, itype_i, store_i, load_i, branch_i, jal_i,
           jalr_i, lui_i, auipc_i, csr_i, tag_i, flush_i, ready_i,
    input  ready_o, valid_o, aluop_o, illegal_o, tag_o, illegal_cnt_o
  );

  modport slave (
    input  valid_i, rtype_i, itype_i, store_i, load_i, branch_i, jal_i,
           jalr_i, lui_i, auipc_i, csr_i, tag_i, flush_i, ready_i,
    output ready_o, valid_o, aluop_o, illegal_o, tag_o, illegal_cnt_o
  );
endinterface

// File: rtl/aluop_decode_pipe.sv
// ---------------------------------------------------------------------------
// aluop_decode_pipe
// Elastic, STAGES-deep pipelined ALU-op decoder. The one-hot class vector is
// encoded combinationally at the input and carried with its tag through a
// chain of valid-qualified register stages. Each stage refills whenever it is
// empty or handing its entry onward, so the pipe streams one entry per cycle
// and holds up to STAGES entries under backpressure.
// Ports:
//   clk_i  : clock, all state on rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : aluop_decode_pipe_if.slave (handshakes, flags, tag, flush,
//            decoded outputs and illegal-decode counter)
// ---------------------------------------------------------------------------
module aluop_decode_pipe #(
  parameter int STAGES  = 2,
  parameter int ALUOP_W = 4,
  parameter int TAG_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  aluop_decode_pipe_if.slave    bus
);

  // Returns {illegal, code[3:0]}. Flag vector bit order is
  // {csr, auipc, lui, jalr, jal, branch, load, store, itype, rtype}; any
  // pattern that is not exactly one-hot decodes to illegal / 4'b1111.
  function automatic logic [4:0] encode_class(input logic [9:0] flags);
    logic [4:0] res;
    res = {1'b1, 4'b1111};
    case (flags)
      10'b00_0000_0001: res = {1'b0, 4'b0000}; // rtype
      10'b00_0000_0010: res = {1'b0, 4'b0001}; // itype
      10'b00_0000_0100: res = {1'b0, 4'b0101}; // store
      10'b00_0000_1000: res = {1'b0, 4'b0100}; // load
      10'b00_0001_0000: res = {1'b0, 4'b0010}; // branch
      10'b00_0010_0000: res = {1'b0, 4'b0011}; // jal
      10'b00_0100_0000: res = {1'b0, 4'b0011}; // jalr
      10'b00_1000_0000: res = {1'b0, 4'b0110}; // lui
      10'b01_0000_0000: res = {1'b0, 4'b0111}; // auipc
      10'b10_0000_0000: res = {1'b0, 4'b1000}; // csr
      default:          res = {1'b1, 4'b1111};
    endcase
    return res;
  endfunction

  logic               valid_r   [STAGES];
  logic [ALUOP_W-1:0] aluop_r   [STAGES];
  logic               illegal_r [STAGES];
  logic [TAG_W-1:0]   tag_r     [STAGES];
  logic [CNT_W-1:0]   illegal_cnt_r;

  logic               src_valid_s   [STAGES];
  logic [ALUOP_W-1:0] src_aluop_s   [STAGES];
  logic               src_illegal_s [STAGES];
  logic [TAG_W-1:0]   src_tag_s     [STAGES];

  logic [STAGES-1:0]  load_s;
  logic [9:0]         flags_s;
  logic [4:0]         enc_s;
  logic               ready_s;
  logic               in_fire_s;

  assign flags_s = {bus.csr_i, bus.auipc_i, bus.lui_i, bus.jalr_i, bus.jal_i,
                    bus.branch_i, bus.load_i, bus.store_i, bus.itype_i,
                    bus.rtype_i};
  assign enc_s   = encode_class(flags_s);

  // Stage-load enables: stage k can take a new entry unless it and every
  // stage after it are full while the consumer stalls.
  always_comb begin
    logic tail_full_s;
    load_s      = {STAGES{1'b0}};
    tail_full_s = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      tail_full_s = tail_full_s & valid_r[k];
      load_s[k]   = bus.ready_i | ~tail_full_s;
    end
  end

  // Input acceptance; flush blocks any transfer in its cycle.
  always_comb begin
    ready_s   = ~bus.flush_i & load_s[0];
    in_fire_s = bus.valid_i & ready_s;
  end

  // Source of each stage: the encoder for stage 0, the previous stage otherwise.
  always_comb begin
    src_valid_s[0]   = in_fire_s;
    src_aluop_s[0]   = ALUOP_W'(enc_s[3:0]);
    src_illegal_s[0] = enc_s[4];
    src_tag_s[0]     = bus.tag_i;
    for (int k = 1; k < STAGES; k++) begin
      src_valid_s[k]   = valid_r[k-1];
      src_aluop_s[k]   = aluop_r[k-1];
      src_illegal_s[k] = illegal_r[k-1];
      src_tag_s[k]     = tag_r[k-1];
    end
  end

  // Pipeline stage registers. Data only loads alongside a valid entry so a
  // bubble never disturbs what is already sitting in a stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_r[k]   <= 1'b0;
        aluop_r[k]   <= {ALUOP_W{1'b0}};
        illegal_r[k] <= 1'b0;
        tag_r[k]     <= {TAG_W{1'b0}};
      end
    end else if (bus.flush_i) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_r[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load_s[k]) begin
          valid_r[k] <= src_valid_s[k];
          if (src_valid_s[k]) begin
            aluop_r[k]   <= src_aluop_s[k];
            illegal_r[k] <= src_illegal_s[k];
            tag_r[k]     <= src_tag_s[k];
          end
        end
      end
    end
  end

  // Saturating illegal-decode counter; counts at acceptance, so later
  // flushes never take a count back.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_cnt_r <= {CNT_W{1'b0}};
    end else if (in_fire_s && enc_s[4] && (illegal_cnt_r != {CNT_W{1'b1}})) begin
      illegal_cnt_r <= illegal_cnt_r + CNT_W'(1'b1);
    end else begin
      illegal_cnt_r <= illegal_cnt_r;
    end
  end

  assign bus.ready_o       = ready_s;
  assign bus.valid_o       = valid_r[STAGES-1];
  assign bus.aluop_o       = aluop_r[STAGES-1];
  assign bus.illegal_o     = illegal_r[STAGES-1];
  assign bus.tag_o         = tag_r[STAGES-1];
  assign bus.illegal_cnt_o = illegal_cnt_r;

endmodule

// File: tb/tb_aluop_decode_pipe.sv
// ---------------------------------------------------------------------------
// tb_aluop_decode_pipe
// Scoreboard bench for aluop_decode_pipe: accepted inputs push the reference
// model's answer into a queue; a monitor pops and compares on each output
// transfer, and also checks output stability under backpressure and the
// illegal-decode counter every cycle.
// ---------------------------------------------------------------------------
module tb_aluop_decode_pipe;
  localparam int STAGES  = 2;
  localparam int ALUOP_W = 4;
  localparam int TAG_W   = 5;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  // Codes by flag index: rtype,itype,store,load,branch,jal,jalr,lui,auipc,csr
  localparam int CODE_TABLE [10] = '{0, 1, 5, 4, 2, 3, 3, 6, 7, 8};

  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic               illegal;
    logic [TAG_W-1:0]   tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aluop_decode_pipe_if #(.ALUOP_W(ALUOP_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  aluop_decode_pipe #(.STAGES(STAGES), .ALUOP_W(ALUOP_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  exp_t sb [$];
  int   pop_cyc [$];
  int   acc_cyc [$];
  int   pop_op [$];
  int   pop_tag [$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cnt_model = 0;
  bit   rand_ready_en = 1'b0;
  bit   stall_seen = 1'b0;
  logic [ALUOP_W+TAG_W:0] held;
  exp_t e_mon;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: count set flags; exactly one selects its table code.
  function automatic exp_t ref_model(input logic [9:0] f, input logic [TAG_W-1:0] t);
    int   ones = 0;
    int   idx = 0;
    exp_t e;
    for (int i = 0; i < 10; i++) if (f[i]) begin ones++; idx = i; end
    e.tag = t;
    if (ones == 1) begin e.aluop = ALUOP_W'(CODE_TABLE[idx]); e.illegal = 1'b0; end
    else           begin e.aluop = ALUOP_W'(15);              e.illegal = 1'b1; end
    return e;
  endfunction

  function automatic logic [9:0] onehot(input int i);
    logic [9:0] f;
    f = 10'd1;
    return f << i;
  endfunction

  // Monitor: all sampling on the falling edge, between active edges.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
      cnt_model  = 0;
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        chk("hold_valid", bus.valid_o, 1);
        chk("hold_data", {bus.aluop_o, bus.illegal_o, bus.tag_o}, held);
      end
      chk("illegal_cnt", bus.illegal_cnt_o, cnt_model);
      if (bus.valid_o && bus.ready_i) begin
        if (sb.size() == 0) begin
          chk("spurious_out", bus.valid_o, 0);
        end else begin
          e_mon = sb.pop_front();
          chk("aluop", bus.aluop_o, e_mon.aluop);
          chk("illegal", bus.illegal_o, e_mon.illegal);
          chk("tag", bus.tag_o, e_mon.tag);
          pop_cyc.push_back(cyc);
          pop_op.push_back(int'(bus.aluop_o));
          pop_tag.push_back(int'(bus.tag_o));
        end
      end
      stall_seen = bus.valid_o && !bus.ready_i && !bus.flush_i;
      held       = {bus.aluop_o, bus.illegal_o, bus.tag_o};
      if (bus.valid_i && bus.ready_o) begin
        e_mon = ref_model({bus.csr_i, bus.auipc_i, bus.lui_i, bus.jalr_i, bus.jal_i,
                           bus.branch_i, bus.load_i, bus.store_i, bus.itype_i, bus.rtype_i},
                          bus.tag_i);
        sb.push_back(e_mon);
        acc_cyc.push_back(cyc);
        if (e_mon.illegal && cnt_model < CNT_MAX) cnt_model++;
      end
      if (bus.flush_i) sb.delete();
    end
  end

  // Random downstream backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready_en) bus.ready_i = ($urandom_range(0, 3) != 0);
  end

  task automatic set_in(input logic [9:0] f, input logic [TAG_W-1:0] t, input logic v);
    bus.rtype_i  = f[0]; bus.itype_i = f[1]; bus.store_i = f[2]; bus.load_i  = f[3];
    bus.branch_i = f[4]; bus.jal_i   = f[5]; bus.jalr_i  = f[6]; bus.lui_i   = f[7];
    bus.auipc_i  = f[8]; bus.csr_i   = f[9];
    bus.tag_i    = t;
    bus.valid_i  = v;
  endtask

  // Offer one entry (called #1 after a rising edge); returns #1 after the
  // accepting edge.
  task automatic send(input logic [9:0] f, input logic [TAG_W-1:0] t);
    bit acc = 1'b0;
    set_in(f, t, 1'b1);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      acc = bus.ready_o;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    chk("send_accept", acc, 1);
    bus.valid_i = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.valid_o) begin done = 1'b1; break; end
    end
    chk("drain", done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_cyc.delete(); acc_cyc.delete(); pop_op.delete(); pop_tag.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] f;
    int a;
    int b;

    // Reset held with an entry offered.
    rst_n = 1'b0;
    bus.ready_i = 1'b1;
    bus.flush_i = 1'b0;
    set_in(10'b00_0000_0001, 5'd0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_aluop", bus.aluop_o, 0);
    chk("rst_illegal", bus.illegal_o, 0);
    chk("rst_tag", bus.tag_o, 0);
    chk("rst_cnt", bus.illegal_cnt_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 bus.valid_i = 1'b0;
    @(negedge clk); chk("lat_early", bus.valid_o, 0);
    @(negedge clk); chk("lat_first", bus.valid_o, 1);
    chk("lat_first_tag", bus.tag_o, 0);
    drain();

    // Streaming all ten classes back-to-back.
    clear_logs();
    for (int i = 0; i < 10; i++) send(onehot(i), 5'(i));
    drain();
    chk("stream_count", pop_op.size(), 10);
    if (pop_op.size() == 10 && acc_cyc.size() == 10) begin
      int exp_seq [10] = '{0, 1, 5, 4, 2, 3, 3, 6, 7, 8};
      for (int i = 0; i < 10; i++) begin
        chk("stream_op", pop_op[i], exp_seq[i]);
        chk("stream_tag", pop_tag[i], i);
      end
      chk("stream_latency", pop_cyc[0] - acc_cyc[0], STAGES);
      chk("stream_gapless", pop_cyc[9] - pop_cyc[0], 9);
    end

    // Illegal decodes.
    clear_logs();
    send(10'b00_0000_0000, 5'd3);
    send(10'b00_0000_1001, 5'd4);
    drain();
    chk("ill_count", pop_op.size(), 2);
    if (pop_op.size() == 2) begin
      chk("ill_op0", pop_op[0], 15);
      chk("ill_op1", pop_op[1], 15);
    end
    chk("ill_cnt2", bus.illegal_cnt_o, 2);

    // Backpressure: two held, third stalls.
    clear_logs();
    bus.ready_i = 1'b0;
    set_in(onehot(1), 5'd10, 1'b1);
    @(negedge clk); chk("bp_rdy0", bus.ready_o, 1);
    @(posedge clk); #1 set_in(onehot(2), 5'd11, 1'b1);
    @(negedge clk); chk("bp_rdy1", bus.ready_o, 1);
    @(posedge clk); #1 set_in(onehot(3), 5'd12, 1'b1);
    @(negedge clk); chk("bp_full", bus.ready_o, 0);
    chk("bp_valid", bus.valid_o, 1);
    chk("bp_head_tag", bus.tag_o, 10);
    repeat (2) @(negedge clk);
    chk("bp_still_full", bus.ready_o, 0);
    @(posedge clk); #1 bus.ready_i = 1'b1;
    send(onehot(3), 5'd12);
    drain();
    chk("bp_count", pop_tag.size(), 3);
    if (pop_tag.size() == 3) begin
      chk("bp_order0", pop_tag[0], 10);
      chk("bp_order1", pop_tag[1], 11);
      chk("bp_order2", pop_tag[2], 12);
    end

    // Flush with two entries in flight (one illegal) and an illegal offer.
    bus.ready_i = 1'b0;
    send(onehot(0), 5'd20);
    send(10'b00_0000_0000, 5'd21);
    set_in(10'b00_0000_0011, 5'd22, 1'b1);
    bus.flush_i = 1'b1;
    bus.ready_i = 1'b1;
    @(negedge clk); chk("fl_ready", bus.ready_o, 0);
    @(posedge clk); #1 bus.flush_i = 1'b0; bus.valid_i = 1'b0;
    @(negedge clk);
    chk("fl_valid", bus.valid_o, 0);
    chk("fl_cnt", bus.illegal_cnt_o, 3);
    repeat (3) @(negedge clk);
    chk("fl_not_accepted", bus.valid_o, 0);
    @(posedge clk); #1;

    // Randomized traffic with backpressure and occasional flushes.
    rand_ready_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) < 65) f = onehot($urandom_range(0, 9));
      else f = 10'($urandom);
      send(f, 5'($urandom));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      if ($urandom_range(0, 49) == 0) begin
        bus.flush_i = 1'b1;
        @(posedge clk); #1 bus.flush_i = 1'b0;
      end
    end
    rand_ready_en = 1'b0;
    @(posedge clk); #1 bus.ready_i = 1'b1;
    drain();

    // Drive the counter into saturation.
    for (int n = 0; n < 260; n++) begin
      a = $urandom_range(0, 9);
      b = (a + 1 + $urandom_range(0, 8)) % 10;
      f = ($urandom_range(0, 4) == 0) ? 10'd0 : (onehot(a) | onehot(b));
      send(f, 5'($urandom));
    end
    drain();
    chk("sat_cnt", bus.illegal_cnt_o, CNT_MAX);

    // Asynchronous reset between edges with two entries in flight.
    bus.ready_i = 1'b0;
    send(onehot(4), 5'd1);
    send(onehot(5), 5'd2);
    chk("ar_pre_valid", bus.valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid_drop", bus.valid_o, 0);
    chk("ar_cnt_clear", bus.illegal_cnt_o, 0);
    @(posedge clk); #1 rst_n = 1'b1; bus.ready_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("ar_empty", bus.valid_o, 0);
    chk("ar_ready", bus.ready_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/aluop_decode_pipe.md
Name: aluop_decode_pipe

Overview:
- Pipelined, elastic successor to the combinational ALU-op decoder in the decode stage.
- Takes one-hot instruction-class flags plus a tag, and produces the ALU op code, an illegal flag and the tag after STAGES register stages.
- Uses a valid/ready handshake on both sides, supports flush, and keeps a saturating count of illegal decodes.
- Sits between instruction decode and the execute-stage ALU control.

Parameters:
STAGES, 2, number of pipeline register stages (>=1); also the minimum latency in cycles
ALUOP_W, 4, width of the aluop code (>=4; upper bits zero-filled)
TAG_W, 5, width of the opaque tag carried alongside each op (e.g. rd index)
CNT_W, 8, width of the saturating illegal-decode counter

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
valid_i  input  1  upstream has a class vector
ready_o  output  1  block can accept this cycle
rtype_i  input  1  R-type class flag
itype_i  input  1  I-type ALU class flag
store_i  input  1  store class flag
load_i  input  1  load class flag
branch_i  input  1  branch class flag
jal_i  input  1  JAL class flag
jalr_i  input  1  JALR class flag
lui_i  input  1  LUI class flag
auipc_i  input  1  AUIPC class flag
csr_i  input  1  CSR class flag
tag_i  input  TAG_W  tag accompanying the flags
flush_i  input  1  synchronous pipeline flush
valid_o  output  1  output stage holds a result
ready_i  input  1  downstream accepts this cycle
aluop_o  output  ALUOP_W  decoded op code
illegal_o  output  1  flag vector was not exactly one-hot
tag_o  output  TAG_W  tag of the output entry
illegal_cnt_o  output  CNT_W  saturating count of illegal entries accepted

Behaviour:
- Reset (rst_ni low, asynchronous): all stage valid bits 0, data registers 0, and illegal_cnt_o 0. Therefore valid_o=0, aluop_o=0, illegal_o=0, tag_o=0. Reset asserted mid-transfer discards all in-flight entries.
- Encoding, applied combinationally at the input and registered into stage 0:
  - rtype=0000, itype=0001, branch=0010, jal=0011, jalr=0011, load=0100, store=0101, lui=0110, auipc=0111, csr=1000.
  - Zero flags or more than one flag set: aluop=1111 and illegal=1. Otherwise illegal=0.
  - Bits above 3 are always 0.
- Handshake:
  - Input transfer occurs when valid_i && ready_o.
  - Output transfer occurs when valid_o && ready_i.
  - valid_i and the input data must be held while ready_o=0.
  - valid_o and the output data are held stable while ready_i=0.
- Stage k advance rule: stage k loads from stage k-1 (or from the input for k=0) when stage k is empty or stage k is itself advancing. Stage STAGES-1 advances when ready_i=1.
- ready_o = !stage0_valid || stage0_advancing. This is a combinational path from ready_i, which is allowed.
- Latency and throughput:
  - An entry accepted at edge t appears with valid_o=1 after edge t+STAGES-1, i.e. STAGES cycles, when there is no backpressure.
  - Sustains 1 entry per cycle.
  - With ready_i=0, up to STAGES entries are held, then ready_o drops.
  - Ordering is strictly FIFO.
- Flush (flush_i=1 at an edge):
  - Clears all stage valid bits and ignores any input transfer that cycle.
  - ready_o is forced 0 while flush_i=1.
  - valid_o=0 from the next cycle.
  - illegal_cnt_o is not cleared by flush.
- Counter: increments by 1 on each accepted input transfer with illegal=1 and saturates at 2^CNT_W-1. Flushed entries that were already counted stay counted.
- Simultaneous input and output transfer on a full pipe is legal: occupancy is unchanged and there are no bubbles.

Test Plan:
- Reset: hold rst_ni=0 with valid_i=1 and rtype_i=1 -> valid_o=0, aluop_o=0, illegal_cnt_o=0. Release reset -> first result appears 2 cycles after acceptance.
- Streaming: apply rtype, itype, store, load, branch, jal, jalr, lui, auipc, csr back-to-back with tags 0..9 and ready_i=1 -> aluop_o sequence 0,1,5,4,2,3,3,6,7,8 with tags 0..9, illegal_o=0, no gaps, first valid_o at cycle 2.
- Illegal decodes: all flags 0 (tag 3), then rtype+load (tag 4) -> aluop_o=1111 with illegal_o=1 for both, illegal_cnt_o=2. With CNT_W=2 and 5 illegal entries -> illegal_cnt_o saturates at 3.
- Backpressure: ready_i=0 while streaming 3 entries -> valid_o=1 holding entry 0 stable, ready_o=0 after 2 entries accepted. Raise ready_i -> entries drain in order with no loss or duplication.
- Flush: two entries in flight plus flush_i=1 with valid_i=1 -> ready_o=0 that cycle, valid_o=0 next cycle, offered entry not accepted, illegal_cnt_o unchanged.
- Async reset mid-stream: drop rst_ni between clock edges with 2 entries in flight -> valid_o falls immediately without waiting for a clock edge, and the pipe is empty after release.
